// File: rtl/mem_stage.sv
// Memory stage: drives DMEM in the EX cycle, owns the EX/MEM register,
// UART and counter MMIO, load alignment and writeback selection.
module mem_stage #(
   parameter int unsigned DMEM_AW = 14,
   parameter int unsigned CNT_W   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall_i,
   input  logic [31:0]        alu_result_i,
   input  logic [31:0]        mem_write_i,
   input  logic [3:0]         dmem_we_i,
   input  logic [2:0]         funct3_i,
   input  logic [1:0]         control_uart_i,
   input  logic [4:0]         wb_addr_i,
   input  logic [1:0]         control_wr_mux_i,
   input  logic               control_wb_i,
   input  logic [31:0]        pc_plus_i,
   input  logic               inst_exec_i,
   output logic [DMEM_AW-1:0] dmem_addr_o,
   output logic [31:0]        dmem_din_o,
   output logic [3:0]         dmem_we_o,
   input  logic [31:0]        dmem_dout_i,
   output logic [7:0]         uart_tx_data_o,
   output logic               uart_tx_valid_o,
   input  logic               uart_tx_ready_i,
   input  logic [7:0]         uart_rx_data_i,
   input  logic               uart_rx_valid_i,
   output logic               uart_rx_ready_o,
   output logic [31:0]        wb_data_o,
   output logic [4:0]         wb_addr_o,
   output logic               control_wb_o
);

   localparam logic [31:0] ADDR_STATUS  = 32'h8000_0000;
   localparam logic [31:0] ADDR_RXDATA  = 32'h8000_0004;
   localparam logic [31:0] ADDR_TXDATA  = 32'h8000_0008;
   localparam logic [31:0] ADDR_CYCLE   = 32'h8000_0010;
   localparam logic [31:0] ADDR_INSTRET = 32'h8000_0014;
   localparam logic [31:0] ADDR_CNTCLR  = 32'h8000_0018;

   localparam logic [1:0] UART_NONE  = 2'b00;
   localparam logic [1:0] UART_LOAD  = 2'b01;
   localparam logic [1:0] UART_STORE = 2'b10;

   typedef enum logic {TX_EMPTY, TX_FULL} tx_state_t;

   tx_state_t        tx_state;
   logic [7:0]       tx_data_q;
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] instret_cnt;

   logic [1:0]  wr_mux_q;
   logic        wb_q;
   logic [4:0]  rd_q;
   logic [2:0]  funct3_q;
   logic [1:0]  addr_lo_q;
   logic [31:0] alu_q;
   logic [31:0] pc_plus_q;
   logic [1:0]  uart_q;
   logic [31:0] mmio_q;

   logic        mmio_st;
   logic        tx_store;
   logic        cnt_clr;
   logic [31:0] mmio_rdata;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_data;

   assign dmem_addr_o = alu_result_i[DMEM_AW+1:2];
   assign dmem_din_o  = mem_write_i;
   assign dmem_we_o   = (control_uart_i == UART_NONE && !stall_i) ? dmem_we_i : '0;

   assign mmio_st  = !stall_i && control_uart_i == UART_STORE;
   assign tx_store = mmio_st && alu_result_i == ADDR_TXDATA;
   assign cnt_clr  = mmio_st && alu_result_i == ADDR_CNTCLR;

   assign uart_rx_ready_o = !stall_i && control_uart_i == UART_LOAD &&
                            alu_result_i == ADDR_RXDATA;
   assign uart_tx_valid_o = (tx_state == TX_FULL);
   assign uart_tx_data_o  = tx_data_q;

   // MMIO reads sample state in the EX cycle; the value is carried in the pipeline register.
   always_comb begin
      mmio_rdata = '0;
      case (alu_result_i)
         ADDR_STATUS:  mmio_rdata = {30'b0, uart_rx_valid_i, tx_state == TX_EMPTY};
         ADDR_RXDATA:  mmio_rdata = {24'b0, uart_rx_data_i};
         ADDR_CYCLE:   mmio_rdata = 32'(cycle_cnt);
         ADDR_INSTRET: mmio_rdata = 32'(instret_cnt);
         default:      mmio_rdata = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_mux_q  <= '0;
         wb_q      <= 1'b0;
         rd_q      <= '0;
         funct3_q  <= '0;
         addr_lo_q <= '0;
         alu_q     <= '0;
         pc_plus_q <= '0;
         uart_q    <= '0;
         mmio_q    <= '0;
      end else if (!stall_i) begin
         wr_mux_q  <= control_wr_mux_i;
         wb_q      <= control_wb_i;
         rd_q      <= wb_addr_i;
         funct3_q  <= funct3_i;
         addr_lo_q <= alu_result_i[1:0];
         alu_q     <= alu_result_i;
         pc_plus_q <= pc_plus_i;
         uart_q    <= control_uart_i;
         mmio_q    <= mmio_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else if (cnt_clr) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 1'b1;
         if (inst_exec_i && !stall_i) instret_cnt <= instret_cnt + 1'b1;
      end
   end

   // A store arriving with the handshake replaces the departing byte.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_state  <= TX_EMPTY;
         tx_data_q <= '0;
      end else begin
         case (tx_state)
            TX_EMPTY: begin
               if (tx_store) begin
                  tx_state  <= TX_FULL;
                  tx_data_q <= mem_write_i[7:0];
               end
            end
            TX_FULL: begin
               if (uart_tx_ready_i) begin
                  if (tx_store) tx_data_q <= mem_write_i[7:0];
                  else          tx_state  <= TX_EMPTY;
               end
            end
            default: tx_state <= TX_EMPTY;
         endcase
      end
   end

   always_comb begin
      case (addr_lo_q)
         2'd0:    ld_byte = dmem_dout_i[7:0];
         2'd1:    ld_byte = dmem_dout_i[15:8];
         2'd2:    ld_byte = dmem_dout_i[23:16];
         default: ld_byte = dmem_dout_i[31:24];
      endcase
      ld_half = addr_lo_q[1] ? dmem_dout_i[31:16] : dmem_dout_i[15:0];
      case (funct3_q)
         3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
         3'b100:  load_data = {24'b0, ld_byte};
         3'b101:  load_data = {16'b0, ld_half};
         default: load_data = dmem_dout_i;
      endcase
   end

   always_comb begin
      case (wr_mux_q)
         2'b01:   wb_data_o = (uart_q == UART_LOAD) ? mmio_q : load_data;
         2'b10:   wb_data_o = pc_plus_q;
         default: wb_data_o = alu_q;
      endcase
   end

   assign wb_addr_o    = rd_q;
   assign control_wb_o = wb_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single-cycle vectors against a
// behavioural sync DMEM, plus hand sequences for UART, counters and reset.
module tb_mem_stage;

   logic        clk, rst, stall;
   logic [31:0] alu, wdata, pc_plus;
   logic [3:0]  we;
   logic [2:0]  f3;
   logic [1:0]  uart, wr_mux;
   logic [4:0]  rd;
   logic        wb, inst_exec;
   logic [13:0] dmem_addr;
   logic [31:0] dmem_din, dmem_dout;
   logic [3:0]  dmem_we;
   logic [7:0]  tx_data, rx_data;
   logic        tx_valid, tx_ready, rx_valid, rx_ready;
   logic [31:0] wb_data;
   logic [4:0]  wb_addr;
   logic        ctrl_wb;

   int n_vec = 0;
   int n_err = 0;

   mem_stage #(.DMEM_AW(14), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .stall_i(stall),
      .alu_result_i(alu), .mem_write_i(wdata), .dmem_we_i(we), .funct3_i(f3),
      .control_uart_i(uart), .wb_addr_i(rd), .control_wr_mux_i(wr_mux),
      .control_wb_i(wb), .pc_plus_i(pc_plus), .inst_exec_i(inst_exec),
      .dmem_addr_o(dmem_addr), .dmem_din_o(dmem_din), .dmem_we_o(dmem_we),
      .dmem_dout_i(dmem_dout),
      .uart_tx_data_o(tx_data), .uart_tx_valid_o(tx_valid), .uart_tx_ready_i(tx_ready),
      .uart_rx_data_i(rx_data), .uart_rx_valid_i(rx_valid), .uart_rx_ready_o(rx_ready),
      .wb_data_o(wb_data), .wb_addr_o(wb_addr), .control_wb_o(ctrl_wb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] mem [0:16383];
   always @(posedge clk) begin
      if (dmem_we[0]) mem[dmem_addr][7:0]   <= dmem_din[7:0];
      if (dmem_we[1]) mem[dmem_addr][15:8]  <= dmem_din[15:8];
      if (dmem_we[2]) mem[dmem_addr][23:16] <= dmem_din[23:16];
      if (dmem_we[3]) mem[dmem_addr][31:24] <= dmem_din[31:24];
      dmem_dout <= mem[dmem_addr];
   end

   typedef struct {
      logic [31:0] alu;
      logic [31:0] wdata;
      logic [3:0]  we;
      logic [2:0]  f3;
      logic [1:0]  uart;
      logic [1:0]  mux;
      logic [4:0]  rd;
      logic        wb;
      logic        stall;
      logic [31:0] pc;
      logic [3:0]  exp_we;
      logic [31:0] exp_data;
      logic [4:0]  exp_rd;
      logic        exp_wb;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                        input logic [2:0] f, input logic [1:0] u, input logic [1:0] m,
                        input logic [4:0] r, input logic b, input logic [31:0] p);
      alu = a; wdata = d; we = w; f3 = f; uart = u; wr_mux = m; rd = r; wb = b; pc_plus = p;
   endtask

   task automatic idle();
      drive(32'h0, 32'h0, 4'h0, 3'd0, 2'b00, 2'b00, 5'd0, 1'b0, 32'h0);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0; stall = 1'b0; inst_exec = 1'b0;
      tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      idle();
      #2;
      chk("rst_wb_addr", {27'b0, wb_addr}, 32'h0);
      chk("rst_ctrl_wb", {31'b0, ctrl_wb}, 32'h0);
      chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
      chk("rst_rx_ready", {31'b0, rx_ready}, 32'h0);
      chk("rst_wb_data", wb_data, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      //           alu           wdata         we    f3    uart   mux    rd     wb    stall pc      exp_we exp_data      rd     wb
      vq.push_back('{32'h100,      32'hAABBCCDD, 4'hF, 3'd2, 2'b00, 2'b00, 5'd0,  1'b0, 1'b0, 32'h0,  4'hF, 32'h00000100, 5'd0,  1'b0});
      vq.push_back('{32'h101,      32'h0,        4'h0, 3'd0, 2'b00, 2'b01, 5'd5,  1'b1, 1'b0, 32'h0,  4'h0, 32'hFFFFFFCC, 5'd5,  1'b1});
      vq.push_back('{32'h101,      32'h0,        4'h0, 3'd4, 2'b00, 2'b01, 5'd6,  1'b1, 1'b0, 32'h0,  4'h0, 32'h000000CC, 5'd6,  1'b1});
      vq.push_back('{32'h102,      32'h0,        4'h0, 3'd1, 2'b00, 2'b01, 5'd7,  1'b1, 1'b0, 32'h0,  4'h0, 32'hFFFFAABB, 5'd7,  1'b1});
      vq.push_back('{32'h100,      32'h0,        4'h0, 3'd5, 2'b00, 2'b01, 5'd8,  1'b1, 1'b0, 32'h0,  4'h0, 32'h0000CCDD, 5'd8,  1'b1});
      vq.push_back('{32'h103,      32'h0,        4'h0, 3'd0, 2'b00, 2'b01, 5'd9,  1'b1, 1'b0, 32'h0,  4'h0, 32'hFFFFFFAA, 5'd9,  1'b1});
      vq.push_back('{32'h102,      32'h0,        4'h0, 3'd5, 2'b00, 2'b01, 5'd10, 1'b1, 1'b0, 32'h0,  4'h0, 32'h0000AABB, 5'd10, 1'b1});
      vq.push_back('{32'h100,      32'h0,        4'h0, 3'd2, 2'b00, 2'b01, 5'd11, 1'b1, 1'b0, 32'h0,  4'h0, 32'hAABBCCDD, 5'd11, 1'b1});
      vq.push_back('{32'h200,      32'h0,        4'h0, 3'd0, 2'b00, 2'b10, 5'd1,  1'b1, 1'b0, 32'h44, 4'h0, 32'h00000044, 5'd1,  1'b1});
      vq.push_back('{32'h12345678, 32'h0,        4'h0, 3'd0, 2'b00, 2'b00, 5'd31, 1'b1, 1'b0, 32'h0,  4'h0, 32'h12345678, 5'd31, 1'b1});
      vq.push_back('{32'h80000000, 32'h0,        4'h0, 3'd2, 2'b01, 2'b01, 5'd2,  1'b1, 1'b0, 32'h0,  4'h0, 32'h00000001, 5'd2,  1'b1});
      vq.push_back('{32'h8000000C, 32'h0,        4'h0, 3'd2, 2'b01, 2'b01, 5'd3,  1'b1, 1'b0, 32'h0,  4'h0, 32'h00000000, 5'd3,  1'b1});
      vq.push_back('{32'h80000100, 32'h11111111, 4'hF, 3'd2, 2'b10, 2'b00, 5'd0,  1'b0, 1'b0, 32'h0,  4'h0, 32'h80000100, 5'd0,  1'b0});
      vq.push_back('{32'h100,      32'h0,        4'h0, 3'd2, 2'b00, 2'b01, 5'd7,  1'b1, 1'b0, 32'h0,  4'h0, 32'hAABBCCDD, 5'd7,  1'b1});
      vq.push_back('{32'h100,      32'h0,        4'hF, 3'd2, 2'b00, 2'b00, 5'd9,  1'b1, 1'b1, 32'h0,  4'h0, 32'hAABBCCDD, 5'd7,  1'b1});
      vq.push_back('{32'h100,      32'h0,        4'h0, 3'd2, 2'b00, 2'b01, 5'd12, 1'b1, 1'b0, 32'h0,  4'h0, 32'hAABBCCDD, 5'd12, 1'b1});

      foreach (vq[i]) begin
         drive(vq[i].alu, vq[i].wdata, vq[i].we, vq[i].f3, vq[i].uart, vq[i].mux,
               vq[i].rd, vq[i].wb, vq[i].pc);
         stall = vq[i].stall;
         #1;
         chk($sformatf("v%0d_dmem_we", i), {28'b0, dmem_we}, {28'b0, vq[i].exp_we});
         step();
         chk($sformatf("v%0d_wb_data", i), wb_data, vq[i].exp_data);
         chk($sformatf("v%0d_wb_addr", i), {27'b0, wb_addr}, {27'b0, vq[i].exp_rd});
         chk($sformatf("v%0d_ctrl_wb", i), {31'b0, ctrl_wb}, {31'b0, vq[i].exp_wb});
      end
      stall = 1'b0;
      idle();

      // RX read: one-cycle accept pulse, data returned next cycle
      rx_valid = 1'b1; rx_data = 8'h5A;
      drive(32'h80000004, 32'h0, 4'h0, 3'd2, 2'b01, 2'b01, 5'd3, 1'b1, 32'h0);
      #1 chk("rx_ready_pulse", {31'b0, rx_ready}, 32'h1);
      step();
      idle();
      #1 chk("rx_ready_drop", {31'b0, rx_ready}, 32'h0);
      chk("rx_wb_data", wb_data, 32'h0000005A);
      chk("rx_wb_addr", {27'b0, wb_addr}, 32'd3);
      drive(32'h80000004, 32'h0, 4'h0, 3'd2, 2'b01, 2'b01, 5'd3, 1'b1, 32'h0);
      stall = 1'b1;
      #1 chk("rx_ready_stalled", {31'b0, rx_ready}, 32'h0);
      step();
      stall = 1'b0; rx_valid = 1'b0;
      idle();

      // Counter clear with a retiring instruction in the same cycle
      inst_exec = 1'b1;
      drive(32'h80000018, 32'h0, 4'h0, 3'd2, 2'b10, 2'b00, 5'd0, 1'b0, 32'h0);
      step();
      idle();
      repeat (3) step();
      inst_exec = 1'b0;
      drive(32'h80000014, 32'h0, 4'h0, 3'd2, 2'b01, 2'b01, 5'd4, 1'b1, 32'h0);
      step();
      chk("instret_after_clr", wb_data, 32'd3);
      drive(32'h80000010, 32'h0, 4'h0, 3'd2, 2'b01, 2'b01, 5'd4, 1'b1, 32'h0);
      step();
      chk("cycle_after_clr", wb_data, 32'd4);
      idle();

      // TX buffer: fill, drop while full, status, drain, refill with handshake
      tx_ready = 1'b0;
      drive(32'h80000008, 32'h41, 4'h1, 3'd2, 2'b10, 2'b00, 5'd0, 1'b0, 32'h0);
      #1 chk("tx_store_no_dmem_we", {28'b0, dmem_we}, 32'h0);
      step();
      idle();
      chk("tx_valid_full", {31'b0, tx_valid}, 32'h1);
      chk("tx_data_41", {24'b0, tx_data}, 32'h41);
      drive(32'h80000008, 32'h42, 4'h1, 3'd2, 2'b10, 2'b00, 5'd0, 1'b0, 32'h0);
      step();
      idle();
      chk("tx_drop_data", {24'b0, tx_data}, 32'h41);
      rx_valid = 1'b1;
      drive(32'h80000000, 32'h0, 4'h0, 3'd2, 2'b01, 2'b01, 5'd4, 1'b1, 32'h0);
      step();
      idle();
      rx_valid = 1'b0;
      chk("status_full_rxv", wb_data, 32'h2);
      chk("tx_valid_hold", {31'b0, tx_valid}, 32'h1);
      tx_ready = 1'b1;
      step();
      tx_ready = 1'b0;
      chk("tx_valid_drained", {31'b0, tx_valid}, 32'h0);
      drive(32'h80000008, 32'h43, 4'h1, 3'd2, 2'b10, 2'b00, 5'd0, 1'b0, 32'h0);
      step();
      tx_ready = 1'b1;
      drive(32'h80000008, 32'h44, 4'h1, 3'd2, 2'b10, 2'b00, 5'd0, 1'b0, 32'h0);
      step();
      tx_ready = 1'b0;
      idle();
      chk("tx_hs_refill_valid", {31'b0, tx_valid}, 32'h1);
      chk("tx_hs_refill_data", {24'b0, tx_data}, 32'h44);

      // Asynchronous reset while TX is full, no clock edge involved
      rst = 1'b0;
      #1;
      chk("arst_tx_valid", {31'b0, tx_valid}, 32'h0);
      chk("arst_wb_addr", {27'b0, wb_addr}, 32'h0);
      chk("arst_ctrl_wb", {31'b0, ctrl_wb}, 32'h0);
      chk("arst_wb_data", wb_data, 32'h0);
      drive(32'h80000010, 32'h0, 4'h0, 3'd2, 2'b01, 2'b01, 5'd2, 1'b1, 32'h0);
      #1 rst = 1'b1;
      step();
      chk("arst_cycle_cnt", wb_data, 32'd0);
      drive(32'h80000014, 32'h0, 4'h0, 3'd2, 2'b01, 2'b01, 5'd2, 1'b1, 32'h0);
      step();
      chk("arst_instret_cnt", wb_data, 32'd0);
      drive(32'h80000010, 32'h0, 4'h0, 3'd2, 2'b01, 2'b01, 5'd2, 1'b1, 32'h0);
      step();
      chk("arst_cycle_restart", wb_data, 32'd2);
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
